// File: rtl/seq_div_10by5.sv
// rtl/seq_div_10by5.sv - iterative restoring divider, NW-bit dividend by DW-bit divisor
// One quotient bit per cycle; valid/ready on both sides; divide-by-zero flagged in one cycle.
module seq_div_10by5 #(
   parameter int NW = 10,
   parameter int DW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [NW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [NW-1:0] quotient,
   output logic [DW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = $clog2(NW + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [NW-1:0] q_sr_q, q_sr_d;
   logic [DW-1:0] d_r_q, d_r_d;
   logic [DW-1:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NW-1:0] quotient_q, quotient_d;
   logic [DW-1:0] remainder_q, remainder_d;
   logic          dbz_q, dbz_d;
   logic          out_valid_q, out_valid_d;

   logic [DW:0]   trial;
   logic [DW:0]   diff;
   logic          q_bit;
   logic [DW-1:0] rem_nx;
   logic [NW-1:0] q_sr_nx;

   // rem < d_r holds every step, so trial < 2*d_r and the top bit of the
   // (DW+1)-bit difference is set exactly when trial < d_r.
   assign trial   = {rem_q, q_sr_q[NW-1]};
   assign diff    = trial - {1'b0, d_r_q};
   assign q_bit   = ~diff[DW];
   assign rem_nx  = q_bit ? diff[DW-1:0] : trial[DW-1:0];
   assign q_sr_nx = {q_sr_q[NW-2:0], q_bit};

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

   always_comb begin
      state_d     = state_q;
      q_sr_d      = q_sr_q;
      d_r_d       = d_r_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               q_sr_d = dividend;
               d_r_d  = divisor;
               rem_d  = '0;
               cnt_d  = CW'(NW);
               if (divisor != '0) begin
                  state_d = RUN;
               end else begin
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dividend[DW-1:0];
                  dbz_d       = 1'b1;
                  out_valid_d = 1'b1;
               end
            end
         end
         RUN: begin
            q_sr_d = q_sr_nx;
            rem_d  = rem_nx;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d     = DONE;
               quotient_d  = q_sr_nx;
               remainder_d = rem_nx;
               dbz_d       = 1'b0;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         q_sr_q      <= '0;
         d_r_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_sr_q      <= q_sr_d;
         d_r_q       <= d_r_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_seq_div_10by5.sv
// tb/tb_seq_div_10by5.sv - directed and round-trip checks for seq_div_10by5
module tb_seq_div_10by5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [9:0] dividend = '0;
   logic [4:0] divisor = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [9:0] quotient;
   logic [4:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_div_10by5 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic accept(input logic [9:0] a, input logic [4:0] b);
      int n;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", n < 50, 1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!out_valid && lat < 40);
   endtask

   task automatic do_op(input logic [9:0] a, input logic [4:0] b, input string tag);
      int lat;
      logic [9:0] eq;
      logic [4:0] er;
      logic       ez;
      int         el;
      if (b == 0) begin
         eq = 10'h3FF; er = a[4:0]; ez = 1'b1; el = 1;
      end else begin
         eq = a / b; er = 5'(a % b); ez = 1'b0; el = 10;
      end
      accept(a, b);
      wait_valid(lat);
      check({tag, "_latency"}, lat, el);
      check({tag, "_quot"}, quotient, eq);
      check({tag, "_rem"}, remainder, er);
      check({tag, "_dbz"}, div_by_zero, ez);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_quot", quotient, 0);
      check("rst_rem", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 10'd50;
      divisor  = 5'd5;
      rst_n    = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);
      in_valid = 1'b0;
      @(posedge clk);
      #1 check("no_accept_while_idle_low", in_ready, 1);

      do_op(10'd1023, 5'd31, "d1023_31");
      do_op(10'd1000, 5'd7,  "d1000_7");
      do_op(10'd0,    5'd5,  "d0_5");
      do_op(10'd4,    5'd9,  "d4_9");
      do_op(10'd1023, 5'd1,  "d1023_1");
      do_op(10'h2AB,  5'd0,  "dz_2AB");

      // 700/9 = 77 r 7 with junk operands offered in RUN and DONE
      begin
         int lat;
         accept(10'd700, 5'd9);
         @(negedge clk);
         in_valid = 1'b1; dividend = 10'd3; divisor = 5'd2;
         check("bp_in_ready_run", in_ready, 0);
         @(negedge clk);
         in_valid = 1'b0;
         wait_valid(lat);
         check("bp_latency", lat + 1, 10);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            dividend = 10'd1;
            divisor  = 5'd0;
            check("bp_valid", out_valid, 1);
            check("bp_quot", quotient, 77);
            check("bp_rem", remainder, 7);
            check("bp_dbz", div_by_zero, 0);
            check("bp_in_ready", in_ready, 0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
         check("bp_release", out_valid, 0);
      end

      // asynchronous reset in the middle of RUN
      accept(10'd1023, 5'd31);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_quot", quotient, 0);
      check("mid_rst_rem", remainder, 0);
      check("mid_rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("mid_rst_in_ready", in_ready, 1);
      do_op(10'd100, 5'd3, "d100_3");

      for (int a = 0; a < 32; a++)
         for (int b = 1; b < 32; b++)
            do_op(10'(a * b), 5'(b), $sformatf("rt_%0d_%0d", a, b));

      for (int i = 0; i < 60; i++)
         do_op(10'($urandom_range(0, 1023)), 5'($urandom_range(0, 31)), "rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
